// File: rtl/debounce_multi.sv
// debounce_multi: multi-channel input conditioner.
//
// Each channel of 'noisy' passes through a SYNC_STAGES-deep synchroniser and a
// stability counter. 'clean' follows the synchronised level only after that
// level has been steady for NDELAY cycles. NDELAY == 0 selects bypass mode, in
// which 'clean' is simply the registered synchroniser output. An optional
// long-press detector reports when a channel has stayed high for LONG_DELAY
// cycles.
//
// Parameters:
//   NCH          number of independent channels (1..32)
//   NDELAY       stable cycles required before 'clean' follows; 0 = bypass
//   NBITS        debounce counter width, NDELAY < 2**NBITS
//   SYNC_STAGES  synchroniser depth (2..4)
//   LONG_DELAY   cycles 'clean' must stay 1 for a long press; 0 = disabled
//   LBITS        long-press counter width, LONG_DELAY < 2**LBITS
//   INIT         per-channel reset level of synchroniser, xnew and clean
//
// Ports:
//   clk         clock, all state updates on its rising edge
//   rst         asynchronous active-high reset
//   noisy       raw asynchronous inputs, bit i = channel i
//   clean       debounced level per channel
//   rise        one-cycle pulse, registered with clean going 0->1
//   fall        one-cycle pulse, registered with clean going 1->0
//   long_press  one-cycle pulse when clean has been 1 for LONG_DELAY cycles
//   held        level, set with long_press, cleared when clean falls
//   any_event   OR of all rise, fall and long_press bits

module debounce_multi #(
  parameter int unsigned     NCH         = 4,
  parameter int unsigned     NDELAY      = 650000,
  parameter int unsigned     NBITS       = 20,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter int unsigned     LONG_DELAY  = 0,
  parameter int unsigned     LBITS       = 24,
  parameter logic [NCH-1:0]  INIT        = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] noisy,
  output logic [NCH-1:0] clean,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall,
  output logic [NCH-1:0] long_press,
  output logic [NCH-1:0] held,
  output logic           any_event
);

  // Last synchroniser stage per channel.
  logic [NCH-1:0] s;
  // Next-state values of the registered outputs, built per channel below.
  logic [NCH-1:0] clean_d;
  logic [NCH-1:0] long_press_d;
  logic [NCH-1:0] held_d;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch

    // ---------------------------------------------------------------------
    // Synchroniser: shift noisy[ch] in at bit 0, s[ch] is the oldest bit.
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= {SYNC_STAGES{INIT[ch]}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], noisy[ch]};
      end
    end

    assign s[ch] = sync_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------------
    // Debounce: xnew tracks the latest synchronised level, cnt counts how
    // long it has been steady. clean takes xnew once cnt has saturated.
    // ---------------------------------------------------------------------
    if (NDELAY == 0) begin : g_bypass

      assign clean_d[ch] = s[ch];

    end else begin : g_debounce

      localparam logic [NBITS-1:0] Limit = NBITS'(NDELAY);

      logic             xnew_q;
      logic [NBITS-1:0] cnt_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          xnew_q <= INIT[ch];
          cnt_q  <= '0;
        end else if (s[ch] != xnew_q) begin
          // Any toggle restarts the stability window.
          xnew_q <= s[ch];
          cnt_q  <= '0;
        end else if (cnt_q != Limit) begin
          cnt_q  <= cnt_q + NBITS'(1);
        end
      end

      // The update takes effect only on an edge where s still agrees with
      // xnew; a toggle on that edge has priority and restarts the count.
      assign clean_d[ch] = ((s[ch] == xnew_q) && (cnt_q == Limit)) ? xnew_q : clean[ch];

    end

    // ---------------------------------------------------------------------
    // Long-press detector.
    // ---------------------------------------------------------------------
    if (LONG_DELAY == 0) begin : g_no_long

      assign long_press_d[ch] = 1'b0;
      assign held_d[ch]       = 1'b0;

    end else begin : g_long

      localparam logic [LBITS-1:0] LLimit = LBITS'(LONG_DELAY);
      localparam logic [LBITS-1:0] LLast  = LBITS'(LONG_DELAY - 1);

      logic [LBITS-1:0] lcnt_q;
      logic             lclr;

      // Clear while clean is low, and also on the very edge it falls so that
      // held drops together with the fall pulse.
      assign lclr = ~clean[ch] | ~clean_d[ch];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lcnt_q <= '0;
        end else if (lclr) begin
          lcnt_q <= '0;
        end else if (lcnt_q != LLimit) begin
          lcnt_q <= lcnt_q + LBITS'(1);
        end
      end

      // Pulse on the edge the counter steps from LLast to LLimit; once
      // saturated it never equals LLast again until the next press.
      assign long_press_d[ch] = ~lclr & (lcnt_q == LLast);
      assign held_d[ch]       = ~lclr & (held[ch] | long_press_d[ch]);

    end

  end

  // -----------------------------------------------------------------------
  // Registered outputs shared by all channels.
  // -----------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clean      <= INIT;
      rise       <= '0;
      fall       <= '0;
      long_press <= '0;
      held       <= '0;
    end else begin
      clean      <= clean_d;
      rise       <= clean_d & ~clean;
      fall       <= ~clean_d & clean;
      long_press <= long_press_d;
      held       <= held_d;
    end
  end

  assign any_event = |(rise | fall | long_press);

endmodule
